// File: rtl/fp32_pkg.sv
// Shared FP32 definitions: flag bit positions, canonical quiet NaN,
// NaN detection and the writeback entry layout.
package fp32_pkg;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [31:0] CANON_QNAN = 32'h7FC0_0000;

    localparam int WB_TAG_W = 5;

    typedef struct packed {
        logic [WB_TAG_W-1:0] tag;
        logic [31:0]         data;
        logic [4:0]          flags;
    } wb_entry_t;

    // A NaN has an all-ones exponent and a non-zero mantissa.
    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/fp32_add_writeback_if.sv
// Issue, adder-result, writeback and sticky-flag signals of the FP add
// writeback block. The slave modport is the block itself.
interface fp32_add_writeback_if #(
    parameter int TAG_W = 5
);
    logic             issue_valid;
    logic             issue_ready;
    logic [TAG_W-1:0] issue_tag;
    logic             flush;
    logic [31:0]      pipe_sum;
    logic [4:0]       pipe_flags;
    logic             wb_valid;
    logic             wb_ready;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      wb_data;
    logic [4:0]       wb_flags;
    logic             fflags_clr;
    logic [4:0]       fflags_acc;

    modport slave (
        input  issue_valid, issue_tag, flush, pipe_sum, pipe_flags,
               wb_ready, fflags_clr,
        output issue_ready, wb_valid, wb_tag, wb_data, wb_flags, fflags_acc
    );

    modport master (
        output issue_valid, issue_tag, flush, pipe_sum, pipe_flags,
               wb_ready, fflags_clr,
        input  issue_ready, wb_valid, wb_tag, wb_data, wb_flags, fflags_acc
    );
endinterface

// File: rtl/fp_result_fifo.sv
// Small synchronous FIFO holding captured adder results until writeback.
// The head is read straight from storage, so a write into an empty FIFO
// becomes visible one cycle later.
module fp_result_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 42,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Next-state: a write when full is only allowed alongside a read;
    // pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_rd    = rd_en && !empty;
        do_wr    = wr_en && (!full || do_rd);
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
        end
    end

    // State registers; storage is zeroed on reset so the head reads as 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: rtl/fp32_add_writeback.sv
// Result side of the 4-stage FP32 adder: tracks issued ops through a
// valid/tag delay line, captures sum/flags as they emerge, buffers them
// for register-file writeback and accumulates sticky exception flags.
// Issue is credit-gated so the FIFO can never overflow.
module fp32_add_writeback
    import fp32_pkg::*;
#(
    parameter int LATENCY   = 4,
    parameter int TAG_W     = 5,
    parameter int DEPTH     = 4,
    parameter int CANON_NAN = 1
) (
    input logic                clk,
    input logic                rst,
    fp32_add_writeback_if.slave bus
);
    localparam int CREDIT_W = $clog2(DEPTH) + 1;
    localparam int ENTRY_W  = TAG_W + 32 + 5;

    logic [LATENCY-1:0]  dl_valid_q, dl_valid_d;
    logic [TAG_W-1:0]    dl_tag_q [LATENCY];
    logic [TAG_W-1:0]    dl_tag_d [LATENCY];
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [4:0]          fflags_q, fflags_d;

    logic                issue_fire;
    logic                wb_fire;
    logic                capture;
    logic [31:0]         cap_data;
    logic [ENTRY_W-1:0]  fifo_wr_data;
    logic [ENTRY_W-1:0]  fifo_rd_data;
    logic                fifo_empty;
    logic                unused_fifo_full;
    logic [CREDIT_W-1:0] unused_fifo_count;

    assign bus.issue_ready = (credit_q < CREDIT_W'(DEPTH));
    assign issue_fire      = bus.issue_valid && bus.issue_ready;
    assign wb_fire         = bus.wb_valid && bus.wb_ready;
    assign capture         = dl_valid_q[LATENCY-1];
    assign cap_data        = ((CANON_NAN != 0) && is_nan(bus.pipe_sum)) ? CANON_QNAN : bus.pipe_sum;
    assign fifo_wr_data    = {dl_tag_q[LATENCY-1], cap_data, bus.pipe_flags};

    assign bus.wb_valid    = !fifo_empty;
    assign bus.wb_tag      = fifo_rd_data[ENTRY_W-1 -: TAG_W];
    assign bus.wb_data     = fifo_rd_data[36:5];
    assign bus.wb_flags    = fifo_rd_data[4:0];
    assign bus.fflags_acc  = fflags_q;

    fp_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear   (bus.flush),
        .wr_en   (capture),
        .wr_data (fifo_wr_data),
        .rd_en   (wb_fire),
        .rd_data (fifo_rd_data),
        .full    (unused_fifo_full),
        .empty   (fifo_empty),
        .count   (unused_fifo_count)
    );

    // Delay line mirrors the adder pipeline; a flush kills every stage
    // including an op issued in the same cycle.
    always_comb begin
        dl_valid_d  = {dl_valid_q[LATENCY-2:0], issue_fire};
        dl_tag_d[0] = bus.issue_tag;
        for (int i = 1; i < LATENCY; i++) begin
            dl_tag_d[i] = dl_tag_q[i-1];
        end
        if (bus.flush) begin
            dl_valid_d = '0;
        end
    end

    // Credits count in-flight plus buffered results.
    always_comb begin
        credit_d = credit_q + CREDIT_W'(issue_fire) - CREDIT_W'(wb_fire);
        if (bus.flush) begin
            credit_d = '0;
        end
    end

    // Sticky flags: clear takes effect before the popped flags are merged.
    always_comb begin
        fflags_d = bus.fflags_clr ? 5'd0 : fflags_q;
        if (wb_fire && !bus.flush) begin
            fflags_d = fflags_d | bus.wb_flags;
        end
    end

    // State registers for delay line, credits and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            dl_valid_q <= '0;
            credit_q   <= '0;
            fflags_q   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dl_tag_q[i] <= '0;
            end
        end else begin
            dl_valid_q <= dl_valid_d;
            credit_q   <= credit_d;
            fflags_q   <= fflags_d;
            dl_tag_q   <= dl_tag_d;
        end
    end
endmodule
